result_demux_1to8: RTL and testbench

- Registered 1-to-8 result distributor; the write-side counterpart of the ALU's 8-to-1 result mux.
- Accepts one 64-bit result plus a 3-bit destination select through a valid/ready handshake.
- Holds the result in a single-entry output register and presents it to exactly one of eight consumers, each with its own valid/ready pair.
- Sits between the ALU output and the downstream EX/MEM consumers: writeback path, forwarding latch, branch unit, etc.

---
 rtl/result_demux_1to8_pkg.sv | 8 +
 rtl/result_demux_1to8_if.sv | 23 ++
 rtl/result_demux_1to8_dec_3to8.sv | 9 +
 rtl/result_demux_1to8.sv | 49 ++++
 tb/tb_result_demux_1to8.sv | 136 +++++++++++++
 5 files changed

// File: rtl/result_demux_1to8_pkg.sv
// result_demux_1to8_pkg: shared widths and state encoding for the result distributor
package result_demux_1to8_pkg;
  localparam int WIDTH = 64;
  localparam int N_DEST = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 16;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/result_demux_1to8_if.sv
// result_demux_1to8_if: upstream handshake, per-destination handshakes and drop status
interface result_demux_1to8_if import result_demux_1to8_pkg::*; #(
  parameter int CW = CNT_W
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic [N_DEST-1:0] dest_en;
  logic [N_DEST-1:0] out_valid;
  logic [N_DEST-1:0] out_ready;
  logic [WIDTH-1:0] out_data;
  logic drop_pulse;
  logic [CW-1:0] drop_count;
  modport master (
    output in_valid, in_data, in_sel, dest_en, out_ready,
    input in_ready, out_valid, out_data, drop_pulse, drop_count
  );
  modport slave (
    input in_valid, in_data, in_sel, dest_en, out_ready,
    output in_ready, out_valid, out_data, drop_pulse, drop_count
  );
endinterface

// File: rtl/result_demux_1to8_dec_3to8.sv
// dec_3to8: binary to one-hot decoder with enable
module dec_3to8 import result_demux_1to8_pkg::*; (
  input logic en,
  input logic [SEL_W-1:0] sel,
  output logic [N_DEST-1:0] y
);
  // all-zero when disabled so an empty holding register never raises a valid
  always_comb y = en ? N_DEST'(1) << sel : '0;
endmodule

// File: rtl/result_demux_1to8.sv
// result_demux_1to8: registered 1-to-8 result distributor with drop counter
module result_demux_1to8 import result_demux_1to8_pkg::*; #(
  parameter int CNT_W = result_demux_1to8_pkg::CNT_W
) (
  input logic clk,
  input logic rst_n,
  result_demux_1to8_if.slave bus
);
  state_t state_q;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic drop_q;
  logic full, sel_rdy, drain, accept, load, drop;
  // handshake decode; only the held destination's ready matters
  always_comb begin
    full = state_q == FULL;
    sel_rdy = bus.out_ready[sel_q];
    drain = full && sel_rdy;
    bus.in_ready = rst_n && (!full || sel_rdy);
    accept = bus.in_valid && bus.in_ready;
    load = accept && bus.dest_en[bus.in_sel];
    drop = accept && !bus.dest_en[bus.in_sel];
  end
  // holding register, state and saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop;
      if (drop && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (load) begin
        data_q <= bus.in_data;
        sel_q <= bus.in_sel;
        state_q <= FULL;
      end else if (drain) begin
        state_q <= EMPTY;
      end
    end
  end
  dec_3to8 u_dec (.en(full), .sel(sel_q), .y(bus.out_valid));
  assign bus.out_data = data_q;
  assign bus.drop_pulse = drop_q;
  assign bus.drop_count = cnt_q;
endmodule

// File: tb/tb_result_demux_1to8.sv
// tb_result_demux_1to8: scoreboard bench with a single-slot buffer reference model
module tb_result_demux_1to8;
  import result_demux_1to8_pkg::*;
  typedef struct {int stamp; logic [2:0] sel; logic [63:0] data;} xfer_t;
  typedef struct {int stamp; logic pulse; int cnt;} drop_t;
  logic clk = 0;
  logic rst_n = 0;
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  int drops = 0;
  logic m_full = 0;
  logic [2:0] m_sel = 0;
  xfer_t sb[$];
  drop_t dq[$];
  result_demux_1to8_if b();
  result_demux_1to8_if #(.CW(3)) b2();
  result_demux_1to8 dut (.clk(clk), .rst_n(rst_n), .bus(b));
  result_demux_1to8 #(.CNT_W(3)) dut_s (.clk(clk), .rst_n(rst_n), .bus(b2));
  assign b2.in_valid = b.in_valid;
  assign b2.in_data = b.in_data;
  assign b2.in_sel = b.in_sel;
  assign b2.dest_en = b.dest_en;
  assign b2.out_ready = b.out_ready;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic step(input logic v, input logic [63:0] d, input logic [2:0] s,
                      input logic [7:0] en, input logic [7:0] rdy);
    logic rdy_m, acc;
    @(posedge clk);
    #1;
    b.in_valid = v;
    b.in_data = d;
    b.in_sel = s;
    b.dest_en = en;
    b.out_ready = rdy;
    #1;
    rdy_m = !m_full || rdy[m_sel];
    chk("in_ready", {63'd0, b.in_ready}, {63'd0, rdy_m});
    acc = v && rdy_m;
    if (m_full && rdy[m_sel]) m_full = 0;
    if (acc && en[s]) begin
      sb.push_back('{cyc + 1, s, d});
      m_full = 1;
      m_sel = s;
    end
    if (acc && !en[s]) drops++;
    dq.push_back('{cyc + 1, acc && !en[s], drops});
  endtask
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 0;
    b.in_valid = 1;
    b.in_data = {$urandom, $urandom};
    b.in_sel = 3'($urandom);
    m_full = 0;
    drops = 0;
    sb.delete();
    dq.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_in_ready", {63'd0, b.in_ready}, 64'd0);
      @(posedge clk);
      #1;
      chk("rst_out_valid", {56'd0, b.out_valid}, 64'd0);
      chk("rst_out_data", b.out_data, 64'd0);
      chk("rst_drop_count", {48'd0, b.drop_count}, 64'd0);
      chk("rst_drop_pulse", {63'd0, b.drop_pulse}, 64'd0);
    end
    rst_n = 1;
    b.in_valid = 0;
  endtask
  // monitor: compares presented outputs against the oldest expected transfer and drop event
  always @(negedge clk) begin
    if (rst_n) begin
      logic [7:0] ev;
      drop_t e;
      ev = (sb.size() > 0 && sb[0].stamp <= cyc) ? 8'(1) << sb[0].sel : 8'h00;
      chk("out_valid", {56'd0, b.out_valid}, {56'd0, ev});
      if (ev != 0) begin
        chk("out_data", b.out_data, sb[0].data);
        if ((ev & b.out_ready) != 0) void'(sb.pop_front());
      end
      if (dq.size() > 0 && dq[0].stamp == cyc) begin
        e = dq.pop_front();
        chk("drop_pulse", {63'd0, b.drop_pulse}, {63'd0, e.pulse});
        chk("drop_count", {48'd0, b.drop_count}, 64'(e.cnt > 65535 ? 65535 : e.cnt));
        chk("drop_count_sat3", {61'd0, b2.drop_count}, 64'(e.cnt > 7 ? 7 : e.cnt));
      end
    end
  end
  initial begin
    b.in_valid = 1;
    b.in_data = 0;
    b.in_sel = 0;
    b.dest_en = 8'hFF;
    b.out_ready = 8'h00;
    do_reset(3);
    step(1, 64'hDEADBEEF_00000005, 3'd5, 8'hFF, 8'hFF);
    step(0, 64'd0, 3'd0, 8'hFF, 8'hFF);
    step(0, 64'd0, 3'd0, 8'hFF, 8'hFF);
    step(1, 64'h2222_0000_0000_0002, 3'd2, 8'hFF, 8'h00);
    for (int i = 0; i < 4; i++) step(1, {$urandom, $urandom}, 3'($urandom), 8'hFF, 8'h00);
    step(1, 64'h7777_0000_0000_0007, 3'd7, 8'hFF, 8'h04);
    step(0, 64'd0, 3'd0, 8'hFF, 8'hFF);
    for (int i = 0; i < 8; i++) step(1, {32'hA5A5_0000, 32'(i)}, 3'(i), 8'hFF, 8'hFF);
    step(0, 64'd0, 3'd0, 8'hFF, 8'hFF);
    step(1, 64'h1, 3'd2, 8'hFB, 8'hFF);
    step(1, 64'h2, 3'd2, 8'hFB, 8'hFF);
    step(0, 64'd0, 3'd0, 8'hFB, 8'hFF);
    for (int i = 0; i < 10; i++) step(1, {$urandom, $urandom}, 3'd2, 8'hFB, 8'hFF);
    step(0, 64'd0, 3'd0, 8'hFF, 8'hFF);
    step(1, 64'h3333_0000_0000_0003, 3'd3, 8'hFF, 8'h00);
    step(0, 64'd0, 3'd0, 8'hFF, 8'h00);
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset(2);
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, 3'($urandom),
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
           ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
    end
    for (int i = 0; i < 4; i++) step(0, 64'd0, 3'd0, 8'hFF, 8'hFF);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
